modbus_frame_rx: RTL and testbench

Receive side of the Modbus RTU slave; the counterpart of the response transmitter. Consumes bytes from a uart_byte_rx instance (rx_data / rx_done pulse) and delimits frames by 3.5-character line silence. Computes CRC-16/Modbus on the fly, checks length and slave address, and presents decoded request fields to the command-handling logic with a one-cycle valid or error pulse.

---
 rtl/modbus_frame_rx.sv | 185 ++++++++++++++++++
 tb/tb_modbus_frame_rx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_frame_rx.sv
// rtl/modbus_frame_rx.sv - Modbus RTU request receiver: silence framing, bit-serial CRC-16, address filter.
// Optional define MODBUS_T15_CHECK_EN flags intra-frame gaps of 1.5 characters or more as length errors.
module modbus_frame_rx #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int GAP_BITS  = 35,
    parameter int FRAME_LEN = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic [7:0]  dev_addr,
    output logic [7:0]  rx_func,
    output logic [15:0] rx_field0,
    output logic [15:0] rx_field1,
    output logic        rx_broadcast,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  frame_err_code,
    output logic        rx_busy
);
    localparam int          BPS     = CLK_FREQ / BAUD_RATE;
    localparam logic [31:0] GAP_MAX = 32'(BPS * GAP_BITS - 1);
    localparam logic [3:0]  LEN_C   = 4'(FRAME_LEN);
    localparam int          IDX_W   = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {S_WAIT_IDLE, S_IDLE, S_RECV, S_CHECK} state_t;

    state_t      state_q;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic        gap_exp;
    logic [3:0]  cnt_q;
    logic [7:0]  rbuf_q [FRAME_LEN];
    logic [15:0] crc_q;
    logic [15:0] crc_step;
    logic [7:0]  sh_q;
    logic [3:0]  bit_cnt_q;
    logic        engine_busy;
    logic        overrun_q;
    logic        gap_flag;
    logic [7:0]  func_q;
    logic [15:0] field0_q, field1_q;
    logic        bcast_q, valid_q, err_q, busy_q;
    logic [1:0]  code_q;

    assign gap_exp     = (gap_cnt_q == GAP_MAX);
    assign engine_busy = (bit_cnt_q != 4'd0);
    // One reflected-polynomial step per cycle, data fed LSB first.
    assign crc_step    = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ sh_q[0]) ? 16'hA001 : 16'h0000);

    always_comb begin
        gap_cnt_d = gap_cnt_q;
        if (rx_done) begin
            gap_cnt_d = 32'd0;
        end else if (!gap_exp) begin
            gap_cnt_d = gap_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gap_cnt_q <= 32'd0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end

`ifdef MODBUS_T15_CHECK_EN
    localparam logic [31:0] T15_MAX = 32'(BPS * 15 - 1);
    logic gap_flag_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            gap_flag_q <= 1'b0;
        end else if (state_q == S_CHECK) begin
            gap_flag_q <= 1'b0;
        end else if (state_q == S_RECV && rx_done && gap_cnt_q >= T15_MAX) begin
            gap_flag_q <= 1'b1;
        end
    end
    assign gap_flag = gap_flag_q;
`else
    assign gap_flag = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= S_WAIT_IDLE;
            cnt_q     <= 4'd0;
            crc_q     <= 16'hFFFF;
            sh_q      <= 8'd0;
            bit_cnt_q <= 4'd0;
            overrun_q <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) begin
                rbuf_q[i] <= 8'd0;
            end
            func_q    <= 8'd0;
            field0_q  <= 16'd0;
            field1_q  <= 16'd0;
            bcast_q   <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'd0;
            busy_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (engine_busy) begin
                crc_q     <= crc_step;
                sh_q      <= {1'b0, sh_q[7:1]};
                bit_cnt_q <= bit_cnt_q - 4'd1;
            end
            case (state_q)
                S_WAIT_IDLE: begin
                    if (gap_exp && !rx_done) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (rx_done) begin
                        rbuf_q[0] <= rx_data;
                        cnt_q     <= 4'd1;
                        crc_q     <= 16'hFFFF;
                        sh_q      <= rx_data;
                        bit_cnt_q <= 4'd8;
                        busy_q    <= 1'b1;
                        state_q   <= S_RECV;
                    end
                end
                S_RECV: begin
                    // A byte landing on the gap-expiry cycle still extends the frame.
                    if (rx_done) begin
                        if (cnt_q != 4'hF) begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                        if (cnt_q < LEN_C) begin
                            rbuf_q[cnt_q[IDX_W-1:0]] <= rx_data;
                            sh_q      <= rx_data;
                            bit_cnt_q <= 4'd8;
                        end
                        if (engine_busy) begin
                            overrun_q <= 1'b1;
                        end
                    end else if (gap_exp) begin
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (overrun_q) begin
                        err_q  <= 1'b1;
                        code_q <= 2'd3;
                    end else if (gap_flag || cnt_q != LEN_C) begin
                        err_q  <= 1'b1;
                        code_q <= 2'd2;
                    end else if (crc_q != 16'h0000) begin
                        err_q  <= 1'b1;
                        code_q <= 2'd1;
                    end else if (rbuf_q[0] == dev_addr || rbuf_q[0] == 8'h00) begin
                        valid_q  <= 1'b1;
                        func_q   <= rbuf_q[1];
                        field0_q <= {rbuf_q[2], rbuf_q[3]};
                        field1_q <= {rbuf_q[4], rbuf_q[5]};
                        bcast_q  <= (rbuf_q[0] == 8'h00);
                    end
                    cnt_q     <= 4'd0;
                    overrun_q <= 1'b0;
                    crc_q     <= 16'hFFFF;
                    busy_q    <= 1'b0;
                    state_q   <= S_IDLE;
                end
                default: state_q <= S_WAIT_IDLE;
            endcase
        end
    end

    assign rx_func        = func_q;
    assign rx_field0      = field0_q;
    assign rx_field1      = field1_q;
    assign rx_broadcast   = bcast_q;
    assign frame_valid    = valid_q;
    assign frame_err      = err_q;
    assign frame_err_code = code_q;
    assign rx_busy        = busy_q;
endmodule

// File: tb/tb_modbus_frame_rx.sv
// tb/tb_modbus_frame_rx.sv - self-checking bench for modbus_frame_rx against a frame-level model.
module tb_modbus_frame_rx;
    localparam int CLK_FREQ  = 400;
    localparam int BAUD_RATE = 100;
    localparam int GAP_BITS  = 35;
    localparam int BPS       = CLK_FREQ / BAUD_RATE;
    localparam int GAP       = BPS * GAP_BITS;
    localparam int T15       = BPS * 15;
    localparam int SP        = BPS * 10;
`ifdef MODBUS_T15_CHECK_EN
    localparam bit T15_EN = 1'b1;
`else
    localparam bit T15_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef int iq_t[$];

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_done = 1'b0;
    logic [7:0]  dev_addr = 8'h01;
    logic [7:0]  rx_func;
    logic [15:0] rx_field0, rx_field1;
    logic        rx_broadcast, frame_valid, frame_err, rx_busy;
    logic [1:0]  frame_err_code;

    int checks = 0;
    int errors = 0;
    logic [7:0]  m_func = 8'd0;
    logic [15:0] m_f0 = 16'd0, m_f1 = 16'd0;
    logic        m_bc = 1'b0;
    logic [1:0]  m_code = 2'd0;
    int          m_kind = 0;
    int          obs_nv, obs_ne, obs_lat;
    logic        obs_busy;

    modbus_frame_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .GAP_BITS(GAP_BITS), .FRAME_LEN(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rx_data(rx_data), .rx_done(rx_done),
        .dev_addr(dev_addr), .rx_func(rx_func), .rx_field0(rx_field0), .rx_field1(rx_field1),
        .rx_broadcast(rx_broadcast), .frame_valid(frame_valid), .frame_err(frame_err),
        .frame_err_code(frame_err_code), .rx_busy(rx_busy)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] crc16(input bq_t b, input int n);
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {8'h00, b[i]};
            for (int k = 0; k < 8; k++) begin
                c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
            end
        end
        return c;
    endfunction

    function automatic bq_t make_frame(input logic [7:0] a, input logic [7:0] f,
                                       input logic [15:0] v0, input logic [15:0] v1);
        bq_t q;
        logic [15:0] c;
        q = '{a, f, v0[15:8], v0[7:0], v1[15:8], v1[7:0]};
        c = crc16(q, 6);
        q.push_back(c[7:0]);
        q.push_back(c[15:8]);
        return q;
    endfunction

    function automatic bq_t frame1();
        bq_t q;
        q = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
        return q;
    endfunction

    function automatic iq_t uni_sp(input int n);
        iq_t s;
        s.push_back(20);
        for (int i = 1; i < n; i++) s.push_back(SP);
        return s;
    endfunction

    // Frame-level expectation: classify the whole byte sequence, update held outputs.
    task automatic predict(input bq_t b, input iq_t sp);
        bit ovr, t15;
        ovr = 1'b0;
        t15 = 1'b0;
        for (int i = 1; i < b.size(); i++) begin
            if (sp[i] <= 8) ovr = 1'b1;
            if (sp[i] >= T15) t15 = 1'b1;
        end
        m_kind = 0;
        if (ovr) begin
            m_kind = 2; m_code = 2'd3;
        end else if ((T15_EN && t15) || b.size() != 8) begin
            m_kind = 2; m_code = 2'd2;
        end else if (crc16(b, 8) != 16'h0000) begin
            m_kind = 2; m_code = 2'd1;
        end else if (b[0] == dev_addr || b[0] == 8'h00) begin
            m_kind = 1;
            m_func = b[1];
            m_f0 = {b[2], b[3]};
            m_f1 = {b[4], b[5]};
            m_bc = (b[0] == 8'h00);
        end
    endtask

    task automatic model_reset();
        m_func = 8'd0; m_f0 = 16'd0; m_f1 = 16'd0; m_bc = 1'b0; m_code = 2'd0; m_kind = 0;
    endtask

    task automatic send_byte(input logic [7:0] d, input int pre);
        repeat (pre) @(negedge clk_in);
        rx_data = d;
        rx_done = 1'b1;
        @(negedge clk_in);
        rx_done = 1'b0;
    endtask

    task automatic send_frame(input bq_t b, input iq_t sp);
        for (int i = 0; i < b.size(); i++) begin
            send_byte(b[i], sp[i] - 1);
            if (i == 0) obs_busy = rx_busy;
        end
    endtask

    task automatic observe();
        obs_nv = 0; obs_ne = 0; obs_lat = -1;
        for (int n = 1; n <= GAP + 10; n++) begin
            @(posedge clk_in);
            #1;
            if (frame_valid) begin obs_nv++; obs_lat = n; end
            if (frame_err) begin obs_ne++; obs_lat = n; end
        end
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({frame_valid, frame_err, rx_busy} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b required 000", {frame_valid, frame_err, rx_busy});
        end
        checks++;
        if ({rx_func, rx_field0, rx_field1, rx_broadcast, frame_err_code} !== 43'd0) begin
            errors++; $display("FAIL reset_fields: got %h required 0", {rx_func, rx_field0, rx_field1, rx_broadcast, frame_err_code});
        end
    endtask

    task automatic test_no_initial_gap();
        send_frame(frame1(), uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 0 || obs_ne !== 0) begin
            errors++; $display("FAIL no_gap_ignore: valid=%0d err=%0d required 0/0", obs_nv, obs_ne);
        end
        predict(frame1(), uni_sp(8));
        send_frame(frame1(), uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 1 || obs_ne !== 0) begin
            errors++; $display("FAIL no_gap_accept: valid=%0d err=%0d required 1/0", obs_nv, obs_ne);
        end
    endtask

    task automatic test_valid_frame();
        dev_addr = 8'h01;
        predict(frame1(), uni_sp(8));
        send_frame(frame1(), uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 1 || obs_ne !== 0) begin
            errors++; $display("FAIL valid_pulse: valid=%0d err=%0d required 1/0", obs_nv, obs_ne);
        end
        checks++;
        if (obs_lat !== GAP + 1) begin
            errors++; $display("FAIL valid_latency: got %0d required %0d", obs_lat, GAP + 1);
        end
        checks++;
        if ({rx_func, rx_field0, rx_field1, rx_broadcast} !== {8'h03, 16'h0000, 16'h000A, 1'b0}) begin
            errors++; $display("FAIL valid_fields: got %h %h %h %b required 03 0000 000a 0",
                               rx_func, rx_field0, rx_field1, rx_broadcast);
        end
        checks++;
        if (obs_busy !== 1'b1 || rx_busy !== 1'b0) begin
            errors++; $display("FAIL valid_busy: during=%b after=%b required 1/0", obs_busy, rx_busy);
        end
    endtask

    task automatic test_crc_error();
        bq_t f;
        f = frame1();
        f[7] = 8'hCE;
        predict(f, uni_sp(8));
        send_frame(f, uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 0 || obs_ne !== 1 || frame_err_code !== 2'd1) begin
            errors++; $display("FAIL crc_err: valid=%0d err=%0d code=%0d required 0/1/1", obs_nv, obs_ne, frame_err_code);
        end
        checks++;
        if (rx_func !== 8'h03) begin
            errors++; $display("FAIL crc_hold_func: got %h required 03", rx_func);
        end
    endtask

    task automatic test_addr_broadcast();
        bq_t f;
        dev_addr = 8'h02;
        send_frame(frame1(), uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 0 || obs_ne !== 0 || rx_busy !== 1'b0 || obs_busy !== 1'b1) begin
            errors++; $display("FAIL addr_drop: valid=%0d err=%0d busy=%b/%b required 0/0 1/0",
                               obs_nv, obs_ne, obs_busy, rx_busy);
        end
        f = make_frame(8'h00, 8'h06, 16'h0001, 16'h0003);
        predict(f, uni_sp(8));
        send_frame(f, uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 1 || {rx_broadcast, rx_func, rx_field0, rx_field1} !== {1'b1, 8'h06, 16'h0001, 16'h0003}) begin
            errors++; $display("FAIL broadcast: valid=%0d got %b %h %h %h required 1 06 0001 0003",
                               obs_nv, rx_broadcast, rx_func, rx_field0, rx_field1);
        end
    endtask

    task automatic test_length();
        bq_t f;
        dev_addr = 8'h01;
        for (int t = 0; t < 2; t++) begin
            f = frame1();
            if (t == 0) void'(f.pop_back());
            else f.push_back(8'h55);
            predict(f, uni_sp(f.size()));
            send_frame(f, uni_sp(f.size()));
            observe();
            checks++;
            if (obs_ne !== 1 || obs_nv !== 0 || frame_err_code !== 2'd2) begin
                errors++; $display("FAIL length_%0d: err=%0d valid=%0d code=%0d required 1/0/2",
                                   f.size(), obs_ne, obs_nv, frame_err_code);
            end
        end
    endtask

    task automatic test_overrun();
        iq_t sp;
        sp = uni_sp(8);
        sp[3] = 5;
        predict(frame1(), sp);
        send_frame(frame1(), sp);
        observe();
        checks++;
        if (obs_ne !== 1 || frame_err_code !== m_code || m_code !== 2'd3) begin
            errors++; $display("FAIL overrun: err=%0d code=%0d required 1/3", obs_ne, frame_err_code);
        end
    endtask

    task automatic test_gap_boundary();
        iq_t sp;
        sp = uni_sp(8);
        sp[5] = GAP;
        predict(frame1(), sp);
        send_frame(frame1(), sp);
        observe();
        checks++;
        if (obs_nv !== (m_kind == 1 ? 1 : 0) || obs_ne !== (m_kind == 2 ? 1 : 0) || frame_err_code !== m_code) begin
            errors++; $display("FAIL gap_boundary: valid=%0d err=%0d code=%0d required kind %0d code %0d",
                               obs_nv, obs_ne, frame_err_code, m_kind, m_code);
        end
    endtask

    task automatic test_random();
        dev_addr = 8'($urandom_range(1, 247));
        for (int n = 0; n < 24; n++) begin
            bq_t f;
            iq_t sp;
            logic [7:0] a;
            int sel, r;
            sel = $urandom_range(0, 3);
            a = (sel == 1) ? 8'h00 : (sel == 2) ? 8'(dev_addr + 8'($urandom_range(1, 200))) : dev_addr;
            f = make_frame(a, 8'($urandom), 16'($urandom), 16'($urandom));
            if ($urandom_range(0, 3) == 0) f[$urandom_range(0, 7)] ^= 8'(1 << $urandom_range(0, 7));
            r = $urandom_range(0, 7);
            if (r == 0) void'(f.pop_back());
            if (r == 1) f.push_back(8'($urandom));
            sp = uni_sp(f.size());
            for (int i = 1; i < f.size(); i++) begin
                if ($urandom_range(0, 5) == 0) sp[i] = $urandom_range(9, GAP);
            end
            predict(f, sp);
            send_frame(f, sp);
            observe();
            checks++;
            if (obs_nv !== (m_kind == 1 ? 1 : 0) || obs_ne !== (m_kind == 2 ? 1 : 0)) begin
                errors++; $display("FAIL rand%0d_pulses: valid=%0d err=%0d required kind %0d", n, obs_nv, obs_ne, m_kind);
            end
            checks++;
            if (m_kind != 0 && obs_lat !== GAP + 1) begin
                errors++; $display("FAIL rand%0d_latency: got %0d required %0d", n, obs_lat, GAP + 1);
            end
            checks++;
            if ({rx_func, rx_field0, rx_field1, rx_broadcast, frame_err_code} !== {m_func, m_f0, m_f1, m_bc, m_code}) begin
                errors++; $display("FAIL rand%0d_held: got %h %h %h %b %0d required %h %h %h %b %0d", n,
                                   rx_func, rx_field0, rx_field1, rx_broadcast, frame_err_code,
                                   m_func, m_f0, m_f1, m_bc, m_code);
            end
            checks++;
            if (obs_busy !== 1'b1 || rx_busy !== 1'b0) begin
                errors++; $display("FAIL rand%0d_busy: during=%b after=%b required 1/0", n, obs_busy, rx_busy);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        bq_t f;
        iq_t sp;
        dev_addr = 8'h01;
        f = frame1();
        for (int i = 0; i < 4; i++) send_byte(f[i], SP - 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if ({rx_busy, frame_valid, rx_func, frame_err_code} !== 12'd0) begin
            errors++; $display("FAIL midreset_clear: got %h required 0", {rx_busy, frame_valid, rx_func, frame_err_code});
        end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        model_reset();
        repeat (GAP + 5) @(negedge clk_in);
        predict(f, uni_sp(8));
        send_frame(f, uni_sp(8));
        observe();
        checks++;
        if (obs_nv !== 1 || obs_ne !== 0 || {rx_func, rx_field0, rx_field1} !== {8'h03, 16'h0000, 16'h000A}) begin
            errors++; $display("FAIL midreset_frame: valid=%0d err=%0d fields %h %h %h required 1/0 03 0000 000a",
                               obs_nv, obs_ne, rx_func, rx_field0, rx_field1);
        end
`ifdef MODBUS_T15_CHECK_EN
        sp = uni_sp(8);
        sp[4] = 2 * SP;
        predict(f, sp);
        send_frame(f, sp);
        observe();
        checks++;
        if (obs_ne !== 1 || frame_err_code !== 2'd2) begin
            errors++; $display("FAIL t15_gap: err=%0d code=%0d required 1/2", obs_ne, frame_err_code);
        end
`else
        sp = uni_sp(8);
        sp[4] = 2 * SP;
        predict(f, sp);
        send_frame(f, sp);
        observe();
        checks++;
        if (obs_nv !== 1 || obs_ne !== 0) begin
            errors++; $display("FAIL slow_gap: valid=%0d err=%0d required 1/0", obs_nv, obs_ne);
        end
`endif
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_no_initial_gap();
        test_valid_frame();
        test_crc_error();
        test_addr_broadcast();
        test_length();
        test_overrun();
        test_gap_boundary();
        test_random();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
